scene_commit_ctrl: RTL and testbench
====================================

Name: scene_commit_ctrl

Overview:
- Sits between the jump-game FSM and the graphics renderer; owns every scene input the renderer reads (block/man positions, block types, enables, squeeze, title/gameover).
- Accepts a new target scene from the FSM via req/ack, holds it in shadow registers, and changes renderer inputs only during vertical blanking, so a frame is never drawn with mixed old and new parameters.
- Horizontal positions glide to their targets by at most STEP pixels per frame (slide/scroll animation); all other fields switch at the first blanking interval.

Parameters:
- V_ACTIVE, 600, first non-visible line; blanking when i_y_read >= V_ACTIVE
- STEP, 8, max pixels an x coordinate moves per frame (1..255)
- XW, 11, coordinate width

Ports:
- clk  in  1  system/pixel clock; same clock as the vga scanner
- rst  in  1  asynchronous, active-low reset
- i_y_read  in  XW  current scan line from the vga block
- i_req  in  1  FSM offers a new target scene; hold until o_ack
- o_ack  out  1  one-cycle pulse: request captured into shadow
- o_busy  out  1  high from capture until animation complete
- o_done  out  1  one-cycle pulse: renderer outputs equal target
- i_x_block1, i_x_block2, i_x_man, i_y_man  in  XW each  target coordinates
- i_en_block1, i_en_block2, i_title, i_gameover  in  1 each  target flags
- i_type_block1, i_type_block2  in  2 each  target block types
- i_squeeze_man  in  XW  target squeeze amount
- o_x_block1, o_x_block2, o_x_man, o_y_man, o_squeeze_man  out  XW  renderer inputs
- o_en_block1, o_en_block2, o_title, o_gameover  out  1  renderer inputs
- o_type_block1, o_type_block2  out  2  renderer inputs
- o_frame_cnt  out  16  vblank counter

Behaviour:
- Reset (rst=0, async): all o_ coordinates/types/squeeze = 0; o_en_* = 0; o_title = 1; o_gameover = 0; o_ack = o_busy = o_done = 0; o_frame_cnt = 0; state IDLE; shadow = 0.
- vb = (i_y_read >= V_ACTIVE), registered to vb_q; vb_tick = vb & ~vb_q, exactly one cycle per frame. o_frame_cnt increments on vb_tick and wraps 0xFFFF->0; it counts in every state.
- States:
  - IDLE: o_busy = 0. If i_req=1, capture all i_ fields into shadow, pulse o_ack in the next cycle, go to PEND. Capture takes 1 cycle.
  - PEND: o_busy = 1. On vb_tick, copy flags, types, y_man and squeeze from shadow to outputs. Step x coords in the same cycle (see stepping). Go to ANIM, or to FIN if all x already match.
  - ANIM: on each vb_tick, step every x coordinate. When all three x outputs equal shadow after a step, go to FIN.
  - FIN: pulse o_done for one cycle, return to IDLE. o_busy falls together with the o_done pulse.
- Stepping, per coordinate, unsigned XW-bit compare:
  - if cur < tgt: cur += min(STEP, tgt-cur)
  - if cur > tgt: cur -= min(STEP, cur-tgt)
  - never overshoots; no wrap-around through 0 or 2^XW-1
  - differences are computed at XW+1 bits.
- Outputs change only in a cycle where vb_tick=1; never while vb=0.
- i_req while o_busy=1: ignored, no ack. Shadow is unchanged until return to IDLE. A still-held req is captured the cycle after FIN.
- i_req and vb_tick in the same IDLE cycle: capture only; the commit waits for the next vb_tick.
- Reset mid-animation: outputs return immediately to reset values; the in-flight request is discarded with no ack or done.
- Scanner output x_read is not used; frame sync comes from y only.

Test Plan:
- Reset then release, i_y_read sweeping 0..627: o_title=1, all other outputs 0; o_frame_cnt=1 after the first crossing to y=600.
- Req with x_man=40, en_block1=1, title=0 at y=100: o_ack the next cycle; outputs unchanged until y=600; then en_block1=1, title=0, x_man=8. x_man reads 16, 24, 32, 40 over the next frames; o_done after the 5th vblank in total.
- Glide down, cur x_block1=100 to target 97 with STEP=8: changes to 97 in one vblank with no undershoot; o_done follows.
- Target x_man=2047 from 2044, and 0 from 3: reaches exactly 2047 / 0; no wrap.
- Second req asserted during ANIM: no o_ack until the cycle after o_done; second target captured then.
- rst low during ANIM at x_man=24: all outputs at reset values asynchronously (before the next clk edge); after release, no o_done; FSM in IDLE.

Source files
------------

// File: rtl/scene_commit_ctrl_if.sv
// scene_commit_ctrl_if
//   Bundle of every signal that passes between the jump-game FSM side, the
//   VGA scanner and the scene commit controller. clk and rst are plain ports
//   on the modules that use this interface and are not carried here.
//
//   Scanner -> controller : i_y_read (current scan line)
//   FSM -> controller     : i_req, target scene (i_x_*, i_y_man, i_en_*,
//                           i_type_*, i_squeeze_man, i_title, i_gameover)
//   controller -> FSM     : o_ack, o_busy, o_done, o_frame_cnt
//   controller -> render  : o_x_*, o_y_man, o_squeeze_man, o_en_*, o_type_*,
//                           o_title, o_gameover
//
//   modport master : the side that offers scenes (FSM / scanner)
//   modport slave  : the commit controller itself
interface scene_commit_ctrl_if #(
  parameter int XW = 11
) ();

  logic [XW-1:0] i_y_read;

  logic          i_req;
  logic          o_ack;
  logic          o_busy;
  logic          o_done;

  logic [XW-1:0] i_x_block1;
  logic [XW-1:0] i_x_block2;
  logic [XW-1:0] i_x_man;
  logic [XW-1:0] i_y_man;
  logic          i_en_block1;
  logic          i_en_block2;
  logic          i_title;
  logic          i_gameover;
  logic [1:0]    i_type_block1;
  logic [1:0]    i_type_block2;
  logic [XW-1:0] i_squeeze_man;

  logic [XW-1:0] o_x_block1;
  logic [XW-1:0] o_x_block2;
  logic [XW-1:0] o_x_man;
  logic [XW-1:0] o_y_man;
  logic [XW-1:0] o_squeeze_man;
  logic          o_en_block1;
  logic          o_en_block2;
  logic          o_title;
  logic          o_gameover;
  logic [1:0]    o_type_block1;
  logic [1:0]    o_type_block2;
  logic [15:0]   o_frame_cnt;

  modport master (
    output i_y_read, i_req,
    output i_x_block1, i_x_block2, i_x_man, i_y_man,
    output i_en_block1, i_en_block2, i_title, i_gameover,
    output i_type_block1, i_type_block2, i_squeeze_man,
    input  o_ack, o_busy, o_done, o_frame_cnt,
    input  o_x_block1, o_x_block2, o_x_man, o_y_man, o_squeeze_man,
    input  o_en_block1, o_en_block2, o_title, o_gameover,
    input  o_type_block1, o_type_block2
  );

  modport slave (
    input  i_y_read, i_req,
    input  i_x_block1, i_x_block2, i_x_man, i_y_man,
    input  i_en_block1, i_en_block2, i_title, i_gameover,
    input  i_type_block1, i_type_block2, i_squeeze_man,
    output o_ack, o_busy, o_done, o_frame_cnt,
    output o_x_block1, o_x_block2, o_x_man, o_y_man, o_squeeze_man,
    output o_en_block1, o_en_block2, o_title, o_gameover,
    output o_type_block1, o_type_block2
  );

endinterface

// File: rtl/scene_commit_ctrl.sv
// scene_commit_ctrl
//   Owns every scene parameter the renderer reads. A new target scene is
//   taken from the game FSM with a req/ack handshake into shadow registers
//   and is only ever applied to the renderer inputs in the single cycle at
//   the start of vertical blanking, so no frame mixes old and new values.
//   Flags, types, y_man and squeeze switch at the first blanking interval;
//   the three x coordinates glide toward their targets by at most STEP
//   pixels per frame and never overshoot or wrap.
//
//   Ports
//     clk : pixel clock shared with the VGA scanner
//     rst : asynchronous, active-low reset
//     bus : scene_commit_ctrl_if.slave (handshake, targets, renderer
//           outputs, scan line input, frame counter)
module scene_commit_ctrl #(
  parameter int V_ACTIVE = 600,
  parameter int STEP     = 8,
  parameter int XW       = 11
) (
  input  logic                clk,
  input  logic                rst,
  scene_commit_ctrl_if.slave  bus
);

  localparam logic [XW-1:0] V_ACT  = XW'(V_ACTIVE);
  localparam logic [XW:0]   STEP_W = (XW+1)'(STEP);
  localparam logic [XW-1:0] STEP_X = XW'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ANIM = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state_reg;

  // Frame sync from the scan line only
  logic          vb;
  logic          vb_q_reg;
  logic          vb_tick;
  logic [15:0]   frame_cnt_reg;

  // Handshake outputs
  logic          ack_reg;
  logic          busy_reg;
  logic          done_reg;

  // Shadow copy of the accepted target scene; x coords kept as an array
  // (0 = block1, 1 = block2, 2 = man) so the glide logic is shared.
  logic [XW-1:0] sh_x_reg [3];
  logic [XW-1:0] sh_y_man_reg;
  logic [XW-1:0] sh_squeeze_reg;
  logic          sh_en1_reg;
  logic          sh_en2_reg;
  logic          sh_title_reg;
  logic          sh_gameover_reg;
  logic [1:0]    sh_type1_reg;
  logic [1:0]    sh_type2_reg;

  // Renderer-facing registers
  logic [XW-1:0] x_reg [3];
  logic [XW-1:0] y_man_reg;
  logic [XW-1:0] squeeze_reg;
  logic          en1_reg;
  logic          en2_reg;
  logic          title_reg;
  logic          gameover_reg;
  logic [1:0]    type1_reg;
  logic [1:0]    type2_reg;

  // Next glide position for each x and whether it lands on the target
  logic [XW-1:0] x_in   [3];
  logic [XW-1:0] x_step [3];
  logic [2:0]    x_match;
  logic          all_match;

  assign x_in[0] = bus.i_x_block1;
  assign x_in[1] = bus.i_x_block2;
  assign x_in[2] = bus.i_x_man;

  assign vb      = (bus.i_y_read >= V_ACT);
  assign vb_tick = vb & ~vb_q_reg;

  // Glide: differences are taken one bit wider than the coordinate so the
  // magnitude compare against STEP is exact over the whole range. When the
  // remaining distance is within STEP the target is loaded directly, which
  // is what prevents both overshoot and wrap through 0 / 2^XW-1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_step
      logic          below;
      logic          above;
      logic [XW:0]   up_diff;
      logic [XW:0]   dn_diff;

      assign below   = x_reg[gi] < sh_x_reg[gi];
      assign above   = x_reg[gi] > sh_x_reg[gi];
      assign up_diff = {1'b0, sh_x_reg[gi]} - {1'b0, x_reg[gi]};
      assign dn_diff = {1'b0, x_reg[gi]} - {1'b0, sh_x_reg[gi]};

      assign x_step[gi] = below ? ((up_diff > STEP_W) ? (x_reg[gi] + STEP_X) : sh_x_reg[gi]) :
                          above ? ((dn_diff > STEP_W) ? (x_reg[gi] - STEP_X) : sh_x_reg[gi]) :
                                  x_reg[gi];

      assign x_match[gi] = (x_step[gi] == sh_x_reg[gi]);
    end
  endgenerate

  assign all_match = &x_match;

  // Blanking edge detector and free-running frame counter (all states)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb_q_reg      <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      vb_q_reg <= vb;
      if (vb_tick) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  // Commit FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      ack_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sh_x_reg[i] <= '0;
        x_reg[i]    <= '0;
      end
      sh_y_man_reg    <= '0;
      sh_squeeze_reg  <= '0;
      sh_en1_reg      <= 1'b0;
      sh_en2_reg      <= 1'b0;
      sh_title_reg    <= 1'b0;
      sh_gameover_reg <= 1'b0;
      sh_type1_reg    <= 2'd0;
      sh_type2_reg    <= 2'd0;
      y_man_reg       <= '0;
      squeeze_reg     <= '0;
      en1_reg         <= 1'b0;
      en2_reg         <= 1'b0;
      title_reg       <= 1'b1;
      gameover_reg    <= 1'b0;
      type1_reg       <= 2'd0;
      type2_reg       <= 2'd0;
    end else begin
      ack_reg  <= 1'b0;
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A blanking edge in the capture cycle is deliberately ignored:
          // the commit waits for the next frame.
          if (bus.i_req) begin
            for (int i = 0; i < 3; i++) begin
              sh_x_reg[i] <= x_in[i];
            end
            sh_y_man_reg    <= bus.i_y_man;
            sh_squeeze_reg  <= bus.i_squeeze_man;
            sh_en1_reg      <= bus.i_en_block1;
            sh_en2_reg      <= bus.i_en_block2;
            sh_title_reg    <= bus.i_title;
            sh_gameover_reg <= bus.i_gameover;
            sh_type1_reg    <= bus.i_type_block1;
            sh_type2_reg    <= bus.i_type_block2;
            ack_reg         <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= PEND;
          end
        end

        PEND: begin
          if (vb_tick) begin
            y_man_reg    <= sh_y_man_reg;
            squeeze_reg  <= sh_squeeze_reg;
            en1_reg      <= sh_en1_reg;
            en2_reg      <= sh_en2_reg;
            title_reg    <= sh_title_reg;
            gameover_reg <= sh_gameover_reg;
            type1_reg    <= sh_type1_reg;
            type2_reg    <= sh_type2_reg;
            for (int i = 0; i < 3; i++) begin
              x_reg[i] <= x_step[i];
            end
            state_reg <= all_match ? FIN : ANIM;
          end
        end

        ANIM: begin
          if (vb_tick) begin
            for (int i = 0; i < 3; i++) begin
              x_reg[i] <= x_step[i];
            end
            if (all_match) begin
              state_reg <= FIN;
            end
          end
        end

        FIN: begin
          // busy drops in the same cycle done is presented
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ack         = ack_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_done        = done_reg;
  assign bus.o_frame_cnt   = frame_cnt_reg;
  assign bus.o_x_block1    = x_reg[0];
  assign bus.o_x_block2    = x_reg[1];
  assign bus.o_x_man       = x_reg[2];
  assign bus.o_y_man       = y_man_reg;
  assign bus.o_squeeze_man = squeeze_reg;
  assign bus.o_en_block1   = en1_reg;
  assign bus.o_en_block2   = en2_reg;
  assign bus.o_title       = title_reg;
  assign bus.o_gameover    = gameover_reg;
  assign bus.o_type_block1 = type1_reg;
  assign bus.o_type_block2 = type2_reg;

endmodule

// File: tb/tb_scene_commit_ctrl.sv
// tb_scene_commit_ctrl
//   Directed bench for scene_commit_ctrl. A scene-level model (targets,
//   current scene, "holding a request" flag) predicts every output each
//   cycle; directed checks with hand-computed literals pin the model.
module tb_scene_commit_ctrl;

  localparam int XW   = 11;
  localparam int STEP = 8;
  localparam int VA   = 600;

  typedef struct packed {
    logic [10:0] xb1;
    logic [10:0] xb2;
    logic [10:0] xm;
    logic [10:0] ym;
    logic [10:0] sq;
    logic        en1;
    logic        en2;
    logic        title;
    logic        go;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        ack;
    logic        busy;
    logic        done;
    logic [15:0] fc;
  } view_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scene_commit_ctrl_if #(.XW(XW)) bus ();

  scene_commit_ctrl #(.V_ACTIVE(VA), .STEP(STEP), .XW(XW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit fast  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scan line generator: full 0..627 frames, or a short frame that still
  // visits lines 100 and 600..603 once per frame.
  initial begin
    bus.i_y_read = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fast)
        bus.i_y_read = (bus.i_y_read >= 11'd603) ? 11'd0 :
                       (bus.i_y_read < 11'd100)  ? 11'd100 :
                       (bus.i_y_read < 11'd599)  ? 11'd599 : bus.i_y_read + 11'd1;
      else
        bus.i_y_read = (bus.i_y_read == 11'd627) ? 11'd0 : bus.i_y_read + 11'd1;
    end
  end

  function automatic view_t reset_view();
    view_t v;
    v = '0;
    v.title = 1'b1;
    return v;
  endfunction

  function automatic view_t dut_view();
    view_t v;
    v.xb1 = bus.o_x_block1;  v.xb2 = bus.o_x_block2;  v.xm = bus.o_x_man;
    v.ym = bus.o_y_man;      v.sq = bus.o_squeeze_man;
    v.en1 = bus.o_en_block1; v.en2 = bus.o_en_block2;
    v.title = bus.o_title;   v.go = bus.o_gameover;
    v.t1 = bus.o_type_block1; v.t2 = bus.o_type_block2;
    v.ack = bus.o_ack; v.busy = bus.o_busy; v.done = bus.o_done;
    v.fc = bus.o_frame_cnt;
    return v;
  endfunction

  function automatic string fmt(view_t v);
    return $sformatf("xb1=%0d xb2=%0d xm=%0d ym=%0d sq=%0d en=%0b%0b title=%0b go=%0b t=%0d/%0d ack=%0b busy=%0b done=%0b fc=%0d",
      v.xb1, v.xb2, v.xm, v.ym, v.sq, v.en1, v.en2, v.title, v.go, v.t1, v.t2,
      v.ack, v.busy, v.done, v.fc);
  endfunction

  // Move cur toward tgt by at most STEP, landing exactly on tgt
  function automatic logic [10:0] glide(logic [10:0] cur, logic [10:0] tgt);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > STEP)  return cur + 11'(STEP);
    if (d < -STEP) return cur - 11'(STEP);
    return tgt;
  endfunction

  task automatic set_targets(input view_t t);
    bus.i_x_block1 = t.xb1;  bus.i_x_block2 = t.xb2;  bus.i_x_man = t.xm;
    bus.i_y_man = t.ym;      bus.i_squeeze_man = t.sq;
    bus.i_en_block1 = t.en1; bus.i_en_block2 = t.en2;
    bus.i_title = t.title;   bus.i_gameover = t.go;
    bus.i_type_block1 = t.t1; bus.i_type_block2 = t.t2;
  endtask

  // ---------------- scene-level model ----------------
  view_t m_scene;     // what the renderer should see
  view_t m_tgt;       // accepted target
  bit    m_vb_prev, m_vb_now, m_tick;
  bit    m_hold;      // a request is owned (busy)
  bit    m_fresh;     // target accepted but not yet shown
  bit    m_arrived;   // all x reached target; done due next cycle
  bit    m_ack, m_done;
  int    m_frames;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_scene = reset_view(); m_tgt = '0;
      m_vb_prev = 0; m_hold = 0; m_fresh = 0; m_arrived = 0;
      m_ack = 0; m_done = 0; m_frames = 0;
    end else begin
      m_vb_now  = (int'(bus.i_y_read) >= VA);
      m_tick    = m_vb_now && !m_vb_prev;
      m_vb_prev = m_vb_now;
      if (m_tick) m_frames = (m_frames + 1) % 65536;
      m_ack = 0;
      m_done = 0;
      if (!m_hold) begin
        if (bus.i_req) begin
          m_tgt.xb1 = bus.i_x_block1; m_tgt.xb2 = bus.i_x_block2; m_tgt.xm = bus.i_x_man;
          m_tgt.ym = bus.i_y_man; m_tgt.sq = bus.i_squeeze_man;
          m_tgt.en1 = bus.i_en_block1; m_tgt.en2 = bus.i_en_block2;
          m_tgt.title = bus.i_title; m_tgt.go = bus.i_gameover;
          m_tgt.t1 = bus.i_type_block1; m_tgt.t2 = bus.i_type_block2;
          m_hold = 1; m_fresh = 1; m_arrived = 0; m_ack = 1;
        end
      end else if (m_arrived) begin
        m_done = 1; m_hold = 0; m_arrived = 0;
      end else if (m_tick) begin
        if (m_fresh) begin
          m_scene.ym = m_tgt.ym; m_scene.sq = m_tgt.sq;
          m_scene.en1 = m_tgt.en1; m_scene.en2 = m_tgt.en2;
          m_scene.title = m_tgt.title; m_scene.go = m_tgt.go;
          m_scene.t1 = m_tgt.t1; m_scene.t2 = m_tgt.t2;
          m_fresh = 0;
        end
        m_scene.xb1 = glide(m_scene.xb1, m_tgt.xb1);
        m_scene.xb2 = glide(m_scene.xb2, m_tgt.xb2);
        m_scene.xm  = glide(m_scene.xm,  m_tgt.xm);
        if (m_scene.xb1 == m_tgt.xb1 && m_scene.xb2 == m_tgt.xb2 && m_scene.xm == m_tgt.xm)
          m_arrived = 1;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    view_t exp_v, got_v;
    if (rst) begin
      exp_v      = m_scene;
      exp_v.ack  = m_ack;
      exp_v.busy = m_hold;
      exp_v.done = m_done;
      exp_v.fc   = 16'(m_frames);
      got_v      = dut_view();
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL model cyc=%0d y=%0d got {%s} required {%s}", cyc, bus.i_y_read, fmt(got_v), fmt(exp_v));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic wait_line(input int n);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (int'(bus.i_y_read) == n) return;
    end
    tests++; fails++;
    $display("FAIL wait_line timeout got=%0d required=%0d", bus.i_y_read, n);
  endtask

  task automatic send(input view_t t, output int lat);
    wait_line(100);
    set_targets(t);
    bus.i_req = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.o_ack) begin
        lat = k;
        break;
      end
    end
    bus.i_req = 1'b0;
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL send_ack got=none required=ack");
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.o_done) begin
        dc = cyc;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL wait_done timeout got=none required=done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    view_t t, t2;
    int lat, dc, ac, acks, seen_done, seen_busy;

    bus.i_req = 1'b0;
    t = '0;
    set_targets(t);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_title", bus.o_title, 1);
    chk("rst_x_man", bus.o_x_man, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst = 1'b1;

    wait_line(605);
    chk("frame_cnt_first", bus.o_frame_cnt, 1);
    chk("idle_title", bus.o_title, 1);
    chk("idle_en_block1", bus.o_en_block1, 0);

    // First scene: x_man 0 -> 40 in steps of 8
    t = '0; t.xm = 11'd40; t.en1 = 1'b1; t.title = 1'b0;
    send(t, lat);
    chk("ack_latency", lat, 1);
    wait_line(599);
    chk("hold_title_before_vblank", bus.o_title, 1);
    chk("hold_en1_before_vblank", bus.o_en_block1, 0);
    wait_line(601);
    chk("commit_en_block1", bus.o_en_block1, 1);
    chk("commit_title", bus.o_title, 0);
    chk("x_man_frame1", bus.o_x_man, 8);
    for (int k = 2; k <= 5; k++) begin
      wait_line(601);
      chk($sformatf("x_man_frame%0d", k), bus.o_x_man, 8 * k);
    end
    wait_done(dc);
    chk("frame_cnt_after_5", bus.o_frame_cnt, 6);
    chk("busy_with_done", bus.o_busy, 0);

    fast = 1'b1;

    // Glide down 100 -> 97
    t.xb1 = 11'd100;
    send(t, lat);
    wait_done(dc);
    chk("x_block1_up", bus.o_x_block1, 100);
    t.xb1 = 11'd97;
    send(t, lat);
    wait_line(601);
    chk("x_block1_down_one_frame", bus.o_x_block1, 97);
    wait_done(dc);
    chk("done_after_glide_down", dc >= 0 ? 1 : 0, 1);

    // Top and bottom of the coordinate range
    t.xm = 11'd2044;
    send(t, lat);
    wait_done(dc);
    chk("x_man_2044", bus.o_x_man, 2044);
    t.xm = 11'd2047;
    send(t, lat);
    wait_line(601);
    chk("x_man_top_no_wrap", bus.o_x_man, 2047);
    wait_done(dc);
    t.xm = 11'd3;
    send(t, lat);
    wait_done(dc);
    chk("x_man_3", bus.o_x_man, 3);
    t.xm = 11'd0;
    send(t, lat);
    wait_line(601);
    chk("x_man_bottom_no_wrap", bus.o_x_man, 0);
    wait_done(dc);

    // Second request held during animation
    t.xm = 11'd40;
    send(t, lat);
    wait_line(601);
    chk("anim_first_step", bus.o_x_man, 8);
    t2 = t; t2.xm = 11'd16; t2.go = 1'b1;
    set_targets(t2);
    bus.i_req = 1'b1;
    acks = 0; dc = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.o_ack) acks++;
      if (bus.o_done) begin
        dc = cyc;
        break;
      end
    end
    chk("no_ack_while_busy", acks, 0);
    chk("first_target_kept", bus.o_x_man, 40);
    ac = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.o_ack) begin
        ac = cyc;
        break;
      end
    end
    chk("ack_cycle_after_done", ac - dc, 1);
    bus.i_req = 1'b0;
    wait_done(dc);
    chk("second_target_x_man", bus.o_x_man, 16);
    chk("second_target_gameover", bus.o_gameover, 1);

    // Reset during animation
    t2.xm = 11'd40;
    send(t2, lat);
    wait_line(601);
    chk("pre_reset_x_man", bus.o_x_man, 24);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_x_man", bus.o_x_man, 0);
    chk("async_rst_title", bus.o_title, 1);
    chk("async_rst_gameover", bus.o_gameover, 0);
    chk("async_rst_busy", bus.o_busy, 0);
    chk("async_rst_frame_cnt", bus.o_frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.o_done) seen_done++;
      if (bus.o_busy) seen_busy++;
    end
    chk("no_done_after_reset", seen_done, 0);
    chk("idle_after_reset", seen_busy, 0);
    chk("x_man_stays_reset", bus.o_x_man, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
